// File: rtl/iir_mc_pkg.sv
// Shared definitions for the multi-channel leaky-integrator core.
// Build option: define IIR_MC_SAT_EN to saturate results on overflow.
// Without it, results wrap modulo 2^DOUT_W.
package iir_mc_pkg;

  localparam int DIN_W_DEF  = 8;
  localparam int DOUT_W_DEF = 20;
  localparam int CH_DEF     = 4;
  localparam int K_DEF      = 4;

  typedef enum logic {
    OVF_WRAP = 1'b0,
    OVF_SAT  = 1'b1
  } ovf_mode_e;

`ifdef IIR_MC_SAT_EN
  localparam ovf_mode_e OVF_MODE = OVF_SAT;
`else
  localparam ovf_mode_e OVF_MODE = OVF_WRAP;
`endif

  // A channel tag is always at least one bit wide, even for a single channel.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iir_mc_stage.sv
// Combinational leaky-integrator update: y + x - (y >> K).
// Also flags overflow past 2^DOUT_W-1 and resolves it by saturating or
// wrapping, depending on OVF_MODE (IIR_MC_SAT_EN).
module iir_mc_stage
  import iir_mc_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF,
  parameter int K      = K_DEF
) (
  input  logic [DOUT_W-1:0] y_i,
  input  logic [DIN_W-1:0]  x_i,
  output logic [DOUT_W-1:0] res_o,
  output logic              ovf_o
);

  logic [DOUT_W-1:0] leak;
  logic [DOUT_W:0]   sum;

  // Turn the one-bit-wider sum into a stored/emitted value.
  function automatic logic [DOUT_W-1:0] resolve(input logic [DOUT_W:0] s);
    if ((OVF_MODE == OVF_SAT) && s[DOUT_W]) begin
      return '1;
    end
    return s[DOUT_W-1:0];
  endfunction

  // y - (y >> K) can never underflow, so it stays DOUT_W wide; only the
  // addition of x can carry into bit DOUT_W.
  always_comb begin
    leak  = y_i - (y_i >> K);
    sum   = {1'b0, leak} + {{(DOUT_W + 1 - DIN_W){1'b0}}, x_i};
    ovf_o = sum[DOUT_W];
    res_o = resolve(sum);
  end

endmodule

// File: rtl/iir_mc_core.sv
// Time-multiplexed first-order IIR over CH channels with one shared datapath.
// Stage 1 captures the sample and the channel's previous output, forwarding
// the stage-2 result when both stages work on the same channel. Stage 2
// computes, emits and writes the new state back.
// Build option: IIR_MC_SAT_EN selects saturating overflow handling.
module iir_mc_core
  import iir_mc_pkg::*;
#(
  parameter  int DIN_W  = DIN_W_DEF,
  parameter  int DOUT_W = DOUT_W_DEF,
  parameter  int CH     = CH_DEF,
  parameter  int K      = K_DEF,
  localparam int CH_W   = ch_width(CH)
) (
  input  logic              clk_21,
  input  logic              rst_21,
  input  logic              data_valid_21,
  input  logic [CH_W-1:0]   ch_21,
  input  logic [DIN_W-1:0]  din_21,
  input  logic              clr_21,
  output logic              dout_valid_21,
  output logic [CH_W-1:0]   dout_ch_21,
  output logic [DOUT_W-1:0] dout_21,
  output logic              ovf_21
);

  localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CH);

  logic [DOUT_W-1:0] state_q [CH];

  logic              ch_ok;
  logic [CH_W-1:0]   ch_rd;
  logic              fwd;
  logic              vld_p1_d;
  logic [DOUT_W-1:0] y_p1_d;

  logic              vld_p1_q;
  logic [CH_W-1:0]   ch_p1_q;
  logic [DIN_W-1:0]  x_p1_q;
  logic [DOUT_W-1:0] y_p1_q;

  logic [DOUT_W-1:0] res_p1;
  logic              ovf_p1;

  logic              vld_p2_q;
  logic [CH_W-1:0]   ch_p2_q;
  logic [DOUT_W-1:0] dout_p2_q;
  logic              ovf_q;

  // ---- stage 0 -> 1: accept, read state, forward from stage 2 ----
  // Qualify the sample and pick the previous output for its channel.
  always_comb begin
    ch_ok    = ({1'b0, ch_21} < CH_LIM);
    ch_rd    = ch_ok ? ch_21 : '0;
    vld_p1_d = data_valid_21 && ch_ok && !clr_21;
    fwd      = vld_p1_q && (ch_p1_q == ch_rd);
    y_p1_d   = fwd ? res_p1 : state_q[ch_rd];
  end

  // Stage-1 valid; reset and clear both flush the sample in flight.
  always_ff @(posedge clk_21) begin
    if (rst_21 || clr_21) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
    end
  end

  // Stage-1 data, only loaded for accepted samples.
  always_ff @(posedge clk_21) begin
    if (vld_p1_d) begin
      ch_p1_q <= ch_21;
      x_p1_q  <= din_21;
      y_p1_q  <= y_p1_d;
    end
  end

  // ---- stage 1 -> 2: arithmetic, output register, write-back ----
  iir_mc_stage #(
    .DIN_W  (DIN_W),
    .DOUT_W (DOUT_W),
    .K      (K)
  ) u_stage (
    .y_i   (y_p1_q),
    .x_i   (x_p1_q),
    .res_o (res_p1),
    .ovf_o (ovf_p1)
  );

  // Output register and sticky overflow flag.
  always_ff @(posedge clk_21) begin
    if (rst_21) begin
      vld_p2_q  <= 1'b0;
      ch_p2_q   <= '0;
      dout_p2_q <= '0;
      ovf_q     <= 1'b0;
    end else if (clr_21) begin
      vld_p2_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        ch_p2_q   <= ch_p1_q;
        dout_p2_q <= res_p1;
      end
      if (vld_p1_q && ovf_p1) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Per-channel state holds exactly the value emitted on dout.
  always_ff @(posedge clk_21) begin
    if (rst_21 || clr_21) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= '0;
      end
    end else if (vld_p1_q) begin
      state_q[ch_p1_q] <= res_p1;
    end
  end

  assign dout_valid_21 = vld_p2_q;
  assign dout_ch_21    = ch_p2_q;
  assign dout_21       = dout_p2_q;
  assign ovf_21        = ovf_q;

endmodule

// File: tb/tb_iir_mc_core.sv
// Bench for iir_mc_core: DUT A uses the default widths, DUT B uses
// DOUT_W=10 and CH=5 so overflow and out-of-range tags are reachable.
module tb_iir_mc_core;

  localparam int N  = 4096;
  localparam int KS = 4;
`ifdef IIR_MC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic clr = 1'b0;

  logic        va = 1'b0, vb = 1'b0;
  logic [1:0]  cha = '0;
  logic [2:0]  chb = '0;
  logic [7:0]  xa = '0, xb = '0;

  logic        dv_a, dv_b, ovf_a, ovf_b;
  logic [1:0]  och_a;
  logic [2:0]  och_b;
  logic [19:0] dout_a;
  logic [9:0]  dout_b;

  iir_mc_core u_a (
    .clk_21        (clk),
    .rst_21        (rst),
    .data_valid_21 (va),
    .ch_21         (cha),
    .din_21        (xa),
    .clr_21        (clr),
    .dout_valid_21 (dv_a),
    .dout_ch_21    (och_a),
    .dout_21       (dout_a),
    .ovf_21        (ovf_a)
  );

  iir_mc_core #(.DIN_W(8), .DOUT_W(10), .CH(5), .K(4)) u_b (
    .clk_21        (clk),
    .rst_21        (rst),
    .data_valid_21 (vb),
    .ch_21         (chb),
    .din_21        (xb),
    .clr_21        (clr),
    .dout_valid_21 (dv_b),
    .dout_ch_21    (och_b),
    .dout_21       (dout_b),
    .ovf_21        (ovf_b)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit started = 1'b0;

  // Expected-event calendar indexed by cycle, one row per DUT.
  bit exp_v  [2][N];
  int exp_d  [2][N];
  int exp_c  [2][N];
  bit exp_o  [2][N];
  bit clr_at [2][N];
  bit rst_at [2][N];

  int my    [2][8];
  bit m_ovf [2];
  int nch   [2] = '{4, 5};
  int dw    [2] = '{20, 10};

  int obs_v [2][8][64];
  int obs_n [2][8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  // y[n] = x + y[n-1] - floor(y[n-1]/2^K), resolved against 2^dw-1.
  function automatic int model_step(input int y, input int x, input int w, output bit ov);
    int s;
    int top;
    s   = x + y - (y / (1 << KS));
    top = (1 << w) - 1;
    ov  = (s > top);
    if (ov) return SAT ? top : s - (1 << w);
    return s;
  endfunction

  // One driven cycle: inputs applied just after a rising edge.
  task automatic step_cycle(input int d, input bit v, input int ch, input int x,
                            input bit do_clr, input bit do_rst);
    int c;
    bit ov;
    c = cyc;
    if (d == 0) begin
      va = v; cha = ch[1:0]; xa = x[7:0];
    end else begin
      vb = v; chb = ch[2:0]; xb = x[7:0];
    end
    clr = do_clr;
    rst = do_rst;
    if (do_clr || do_rst) begin
      for (int k = 0; k < 2; k++) begin
        exp_v[k][(c + 1) % N] = 1'b0;
        exp_v[k][(c + 2) % N] = 1'b0;
        clr_at[k][(c + 1) % N] = 1'b1;
        if (do_rst) rst_at[k][(c + 1) % N] = 1'b1;
        for (int j = 0; j < 8; j++) my[k][j] = 0;
      end
    end else if (v && ch < nch[d]) begin
      my[d][ch] = model_step(my[d][ch], x, dw[d], ov);
      exp_v[d][(c + 2) % N] = 1'b1;
      exp_d[d][(c + 2) % N] = my[d][ch];
      exp_c[d][(c + 2) % N] = ch;
      exp_o[d][(c + 2) % N] = ov;
    end
    @(posedge clk);
    #1;
    va = 1'b0; vb = 1'b0; clr = 1'b0; rst = 1'b0;
  endtask

  task automatic send(input int d, input int ch, input int x);
    step_cycle(d, 1'b1, ch, x, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step_cycle(0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic clear_obs();
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 8; j++) obs_n[k][j] = 0;
  endtask

  // Compare both DUTs against the calendar on every falling edge.
  always @(negedge clk) begin
    int i;
    bit v;
    int o;
    int c;
    bit ov;
    if (started) begin
      i = cyc % N;
      for (int d = 0; d < 2; d++) begin
        if (d == 0) begin
          v = dv_a; o = int'(dout_a); c = int'(och_a); ov = ovf_a;
        end else begin
          v = dv_b; o = int'(dout_b); c = int'(och_b); ov = ovf_b;
        end
        if (clr_at[d][i]) m_ovf[d] = 1'b0;
        if (rst_at[d][i]) begin
          chk(d == 0 ? "rst_dout_a" : "rst_dout_b", o, 0);
          chk(d == 0 ? "rst_ch_a" : "rst_ch_b", c, 0);
        end
        chk(d == 0 ? "valid_a" : "valid_b", int'(v), int'(exp_v[d][i]));
        if (exp_v[d][i]) begin
          if (exp_o[d][i]) m_ovf[d] = 1'b1;
          if (v) begin
            chk(d == 0 ? "dout_a" : "dout_b", o, exp_d[d][i]);
            chk(d == 0 ? "dout_ch_a" : "dout_ch_b", c, exp_c[d][i]);
            if (c < 8 && obs_n[d][c] < 64) begin
              obs_v[d][c][obs_n[d][c]] = o;
              obs_n[d][c]++;
            end
          end
        end
        chk(d == 0 ? "ovf_a" : "ovf_b", int'(ov), int'(m_ovf[d]));
        exp_v[d][i]  = 1'b0;
        exp_o[d][i]  = 1'b0;
        clr_at[d][i] = 1'b0;
        rst_at[d][i] = 1'b0;
      end
    end
  end

  int pat [6] = '{10, 200, 37, 255, 0, 99};

  initial begin
    int n0;
    for (int k = 0; k < 2; k++) begin
      m_ovf[k] = 1'b0;
      for (int j = 0; j < N; j++) begin
        exp_v[k][j] = 1'b0; exp_o[k][j] = 1'b0;
        exp_d[k][j] = 0;    exp_c[k][j] = 0;
        clr_at[k][j] = 1'b0; rst_at[k][j] = 1'b0;
      end
      for (int j = 0; j < 8; j++) my[k][j] = 0;
    end
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    step_cycle(0, 1'b0, 0, 0, 1'b0, 1'b1);
    idle(2);

    // Constant 255 on ch0, back to back.
    for (int n = 0; n < 20; n++) send(0, 0, 255);
    idle(3);
    chk("lit_ch0_y1", obs_v[0][0][0], 255);
    chk("lit_ch0_y2", obs_v[0][0][1], 495);
    chk("lit_ch0_y3", obs_v[0][0][2], 720);
    chk("lit_ch0_y4", obs_v[0][0][3], 930);

    // Interleaved channels are independent.
    step_cycle(0, 1'b0, 0, 0, 1'b1, 1'b0);
    idle(2);
    clear_obs();
    for (int n = 0; n < 8; n++) begin
      send(0, 0, 255);
      send(0, 1, 68);
    end
    idle(3);
    chk("lit_il_ch0_y2", obs_v[0][0][1], 495);
    chk("lit_il_ch1_y1", obs_v[0][1][0], 68);
    chk("lit_il_ch1_y2", obs_v[0][1][1], 132);
    chk("lit_il_ch1_y3", obs_v[0][1][2], 192);

    // Back-to-back (forwarded) versus spaced samples give identical sequences.
    clear_obs();
    for (int n = 0; n < 6; n++) send(0, 2, pat[n]);
    idle(3);
    for (int n = 0; n < 6; n++) begin
      send(0, 3, pat[n]);
      idle(2);
    end
    idle(2);
    chk("fwd_count", obs_n[0][3], obs_n[0][2]);
    for (int n = 0; n < 6; n++) chk("fwd_vs_spaced", obs_v[0][2][n], obs_v[0][3][n]);

    // Mixed channel order including same-channel repeats.
    for (int n = 0; n < 40; n++) send(0, int'($urandom_range(3)), int'($urandom_range(255)));
    idle(3);

    // Clear while samples are in flight; a sample presented during clear is dropped.
    send(0, 0, 255);
    send(0, 0, 255);
    step_cycle(0, 1'b1, 0, 255, 1'b1, 1'b0);
    idle(2);
    n0 = obs_n[0][0];
    send(0, 0, 255);
    idle(3);
    chk("clr_first", obs_v[0][0][n0], 255);
    chk("clr_ovf_a", int'(ovf_a), 0);

    // Narrow DUT: overflow behaviour.
    clear_obs();
    for (int n = 0; n < 6; n++) send(1, 0, 255);
    idle(3);
    chk("lit_b_y4", obs_v[1][0][3], 930);
    chk("lit_b_y5", obs_v[1][0][4], SAT ? 1023 : 103);
    chk("lit_b_y6", obs_v[1][0][5], SAT ? 1023 : 352);
    chk("lit_b_ovf", int'(ovf_b), 1);

    // Out-of-range tags: no output, no state change.
    n0 = obs_n[1][0];
    send(1, 5, 200);
    send(1, 6, 200);
    send(1, 7, 200);
    idle(3);
    chk("bad_ch_none", obs_n[1][5] + obs_n[1][6] + obs_n[1][7], 0);
    send(1, 0, 255);
    idle(3);
    chk("bad_ch_state", obs_v[1][0][n0], SAT ? 1023 : 585);

    // Reset with samples in the pipeline.
    clear_obs();
    send(0, 1, 68);
    send(0, 1, 68);
    step_cycle(0, 1'b0, 0, 0, 1'b0, 1'b1);
    idle(2);
    chk("rst_ovf_b", int'(ovf_b), 0);
    send(0, 1, 68);
    idle(3);
    chk("rst_count", obs_n[0][1], 2);
    chk("rst_after", obs_v[0][1][1], 68);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
